// File: rtl/servo_pwm_array_if.sv
// Target-write bus between the control FSM and servo_pwm_array.
// One wr_en strobe per write; wr_ch selects the channel, wr_width is raw microseconds.
interface servo_pwm_array_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 13
);
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_width;

    modport master (output wr_en, wr_ch, wr_width);
    modport slave  (input  wr_en, wr_ch, wr_width);
endinterface

// File: rtl/servo_pwm_array.sv
// N-channel servo PWM generator: shared frame counter, clamped per-channel targets,
// per-frame slew limiting of the output width, registered glitch-free PWM outputs.
module servo_pwm_array #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 13,
    parameter int PERIOD_US = 5000,
    parameter int W_MIN     = 1000,
    parameter int W_MAX     = 2000,
    parameter int W_CENTER  = 1500,
    parameter int STEP      = 50
) (
    input  logic                 clkus,
    input  logic                 rst,
    servo_pwm_array_if.slave     wr,
    input  logic [N_CH-1:0]      en,
    output logic [N_CH-1:0]      pwm,
    output logic                 frame,
    output logic [N_CH-1:0]      settled
);

    localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(PERIOD_US - 1);
    localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(W_MIN);
    localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(W_MAX);
    localparam logic [CNT_W-1:0] C_CENTER = CNT_W'(W_CENTER);
    localparam logic [CNT_W-1:0] C_STEP   = CNT_W'(STEP);
    localparam logic [CNT_W:0]   C_STEP_X = (CNT_W+1)'(STEP);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur    [N_CH];
    logic [CNT_W-1:0] r_target [N_CH];
    logic [N_CH-1:0]  r_en_lat;
    logic [N_CH-1:0]  r_pwm;

    logic             w_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      w_wr_idx;
    logic             w_wr_hit;
    logic [CNT_W-1:0] w_clamped;
    logic [CNT_W:0]   w_sum    [N_CH];
    logic [CNT_W-1:0] w_dn     [N_CH];
    logic [CNT_W-1:0] w_cur_nxt[N_CH];
    logic [CNT_W-1:0] w_tgt_nxt[N_CH];
    logic [N_CH-1:0]  w_en_nxt;
    logic [N_CH-1:0]  w_pwm_nxt;

    assign w_last    = (r_cnt == C_LAST);
    assign w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
    assign w_wr_idx  = 32'(wr.wr_ch);
    assign w_wr_hit  = wr.wr_en && (w_wr_idx < 32'(N_CH));

    // Gated by rst so the strobe stays low while reset is held even though cnt is 0.
    assign frame = rst && (r_cnt == '0);
    assign pwm   = r_pwm;

    always_comb begin
        if (wr.wr_width < C_MIN)
            w_clamped = C_MIN;
        else if (wr.wr_width > C_MAX)
            w_clamped = C_MAX;
        else
            w_clamped = wr.wr_width;
    end

    always_comb begin
        w_cur_nxt = r_cur;
        w_tgt_nxt = r_target;
        w_en_nxt  = r_en_lat;
        w_pwm_nxt = '0;
        settled   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_sum[i] = {1'b0, r_cur[i]} + C_STEP_X;
            w_dn[i]  = r_cur[i] - r_target[i];
            if (w_wr_hit && (w_wr_idx == i))
                w_tgt_nxt[i] = w_clamped;
            // Frame update works on the pre-write target; a same-cycle write lands next frame.
            if (w_last) begin
                w_en_nxt[i] = en[i];
                if (STEP == 0)
                    w_cur_nxt[i] = r_target[i];
                else if (r_target[i] > r_cur[i])
                    w_cur_nxt[i] = (w_sum[i] > {1'b0, r_target[i]}) ? r_target[i]
                                                                    : w_sum[i][CNT_W-1:0];
                else if (r_target[i] < r_cur[i])
                    w_cur_nxt[i] = (w_dn[i] > C_STEP) ? (r_cur[i] - C_STEP) : r_target[i];
            end
            w_pwm_nxt[i] = w_en_nxt[i] && (w_cnt_nxt < w_cur_nxt[i]);
            settled[i]   = (r_cur[i] == r_target[i]);
        end
    end

    always_ff @(posedge clkus or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_en_lat <= '0;
            r_pwm    <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_cur[i]    <= C_CENTER;
                r_target[i] <= C_CENTER;
            end
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_en_lat <= w_en_nxt;
            r_pwm    <= w_pwm_nxt;
            r_cur    <= w_cur_nxt;
            r_target <= w_tgt_nxt;
        end
    end

endmodule
